// File: rtl/vga_sync_capture.sv
// vga_sync_capture: receiving end of the VGA pixel interface.
// Rebuilds the pixel position from sync edges and checks line, hsync-width and
// frame timing. It declares lock after enough clean frames, then emits the
// captured active pixels and a per-frame checksum. All state moves on i_pix_stb.
module vga_sync_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int LOCK_FRAMES = 2,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_stb,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [3:0]  i_red,
  input  logic [3:0]  i_green,
  input  logic [3:0]  i_blue,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic        o_pix_vld,
  output logic [11:0] o_rgb,
  output logic        o_frame_start,
  output logic        o_locked,
  output logic        o_err,
  output logic [15:0] o_frame_sum,
  output logic        o_sum_vld
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  H_LOAD    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_LOAD    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
  localparam logic [15:0] H_TOTAL_C = 16'(H_TOTAL);
  localparam logic [15:0] H_SYNC_C  = 16'(H_SYNC);
  localparam logic [15:0] V_TOTAL_C = 16'(V_TOTAL);
  localparam logic [7:0]  LOCK_C    = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic        hs_q, vs_q;            // previous sampled sync, 1 = asserted
  logic [9:0]  x_q, y_q, x_nxt, y_nxt;
  logic [15:0] lcnt_q;                // strobes since last hsync edge
  logic [15:0] hw_q;                  // asserted strobes in current hsync pulse
  logic [15:0] wcnt_q;                // x-wraps since last vsync edge
  logic [15:0] acc_q;
  logic        hs_act, vs_act, hs_edge, hs_fall, vs_edge, x_wrap;
  logic        line_bad, width_bad, frame_bad, mismatch, active, locked_d;
  logic [11:0] rgb;

  // Counters saturate so a dead sync cannot alias back to a legal period.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign rgb     = {i_red, i_green, i_blue};
  assign hs_act  = (i_hsync == SYNC_POL);
  assign vs_act  = (i_vsync == SYNC_POL);
  assign hs_edge = hs_act & ~hs_q;
  assign hs_fall = ~hs_act & hs_q;
  assign vs_edge = vs_act & ~vs_q;
  // A wrap is only the natural 799->0 step; an hsync reload is not a wrap.
  assign x_wrap  = ~hs_edge & (x_q == H_LAST);

  assign line_bad  = hs_edge & (lcnt_q != H_TOTAL_C);
  assign width_bad = hs_fall & (hw_q != H_SYNC_C);
  assign frame_bad = vs_edge & ((wcnt_q + {15'd0, x_wrap}) != V_TOTAL_C);
  assign mismatch  = (state_q != SEARCH) & (line_bad | width_bad | frame_bad);

  // Position for the pixel sampled on this strobe; both sync loads may apply at once.
  always_comb begin
    x_nxt = x_q + 10'd1;
    if (hs_edge)            x_nxt = H_LOAD;
    else if (x_q == H_LAST) x_nxt = '0;
    y_nxt = y_q;
    if (vs_edge)            y_nxt = V_LOAD;
    else if (x_wrap)        y_nxt = (y_q == V_LAST) ? '0 : y_q + 10'd1;
  end

  assign active   = (x_nxt < H_ACT) & (y_nxt < V_ACT);
  assign locked_d = (state_d == LOCKED);

  // Lock FSM next state: any mismatch drops to SEARCH on the same strobe.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: if (vs_edge) begin
        state_d = TRACK;
        good_d  = '0;
      end
      TRACK: begin
        if (mismatch) state_d = SEARCH;
        else if (vs_edge) begin
          good_d = good_q + 8'd1;
          if (good_q + 8'd1 >= LOCK_C) state_d = LOCKED;
        end
      end
      LOCKED: if (mismatch) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SEARCH;
      good_q  <= '0;
    end else if (i_pix_stb) begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // Sync history, position counters, timing measurements and checksum accumulator.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      lcnt_q <= '0;
      hw_q   <= '0;
      wcnt_q <= '0;
      acc_q  <= '0;
    end else if (i_pix_stb) begin
      hs_q   <= hs_act;
      vs_q   <= vs_act;
      x_q    <= x_nxt;
      y_q    <= y_nxt;
      lcnt_q <= hs_edge ? 16'd1 : sat_inc(lcnt_q);
      if (hs_act) hw_q <= hs_q ? sat_inc(hw_q) : 16'd1;
      if (vs_edge)     wcnt_q <= '0;
      else if (x_wrap) wcnt_q <= sat_inc(wcnt_q);
      acc_q  <= (vs_edge ? 16'd0 : acc_q) + (active ? {4'd0, rgb} : 16'd0);
    end
  end

  assign o_x = x_q;
  assign o_y = y_q;

  // Registered outputs; event outputs are one-clock pulses after the strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pix_vld     <= 1'b0;
      o_rgb         <= '0;
      o_frame_start <= 1'b0;
      o_locked      <= 1'b0;
      o_err         <= 1'b0;
      o_frame_sum   <= '0;
      o_sum_vld     <= 1'b0;
    end else begin
      o_pix_vld     <= 1'b0;
      o_frame_start <= 1'b0;
      o_err         <= 1'b0;
      o_sum_vld     <= 1'b0;
      if (i_pix_stb) begin
        o_locked      <= locked_d;
        o_err         <= mismatch;
        o_pix_vld     <= active & locked_d;
        o_frame_start <= locked_d & (x_nxt == '0) & (y_nxt == '0);
        o_sum_vld     <= vs_edge & locked_d;
        if (active & locked_d) o_rgb <= rgb;
        if (vs_edge) o_frame_sum <= acc_q;
      end
    end
  end
endmodule
